// File: rtl/encoder_responder_pkg.sv
// Encoder protocol definitions shared by the responder and the encoder master side.
// Holds command codes, reply lengths, the FSM state type and the reply byte builder.
package encoder_responder_pkg;

    localparam logic [7:0] CMD_POS = 8'h02;
    localparam logic [7:0] CMD_ID  = 8'h92;
    localparam int unsigned LEN_POS = 6;
    localparam int unsigned LEN_ID  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_START,
        ST_RX_DATA,
        ST_RX_STOP,
        ST_DECODE,
        ST_TX_GUARD,
        ST_TX_BYTE,
        ST_TX_HOLD
    } state_e;

    function automatic logic cmd_valid(input logic [7:0] cmd);
        return (cmd == CMD_POS) || (cmd == CMD_ID);
    endfunction

    function automatic logic [2:0] reply_last(input logic [7:0] cmd);
        return (cmd == CMD_POS) ? 3'(LEN_POS - 1) : 3'(LEN_ID - 1);
    endfunction

    // Final byte of each reply is the XOR of every byte before it.
    function automatic logic [7:0] reply_byte(input logic [7:0]  cmd,
                                              input logic [7:0]  sf,
                                              input logic [23:0] pos,
                                              input logic [7:0]  id,
                                              input logic [2:0]  idx);
        logic [7:0] b;
        if (cmd == CMD_POS) begin
            case (idx)
                3'd0:    b = cmd;
                3'd1:    b = sf;
                3'd2:    b = pos[7:0];
                3'd3:    b = pos[15:8];
                3'd4:    b = pos[23:16];
                default: b = cmd ^ sf ^ pos[7:0] ^ pos[15:8] ^ pos[23:16];
            endcase
        end else begin
            case (idx)
                3'd0:    b = cmd;
                3'd1:    b = sf;
                3'd2:    b = id;
                default: b = cmd ^ sf ^ id;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/encoder_responder_bit_timer.sv
// uart_bit_timer: free-running bit-period counter with mid-bit and end-bit strobes.
// restart_i zeroes the count on the next edge so a new bit period starts there.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 40
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic restart_i,
    output logic mid_o,
    output logic end_o
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        if (restart_i || (cnt_q == CW'(CLKS_PER_BIT - 1))) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mid_o = (cnt_q == CW'(CLKS_PER_BIT / 2 - 1));
    assign end_o = (cnt_q == CW'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/encoder_responder.sv
// RS485 encoder responder: decodes one 8N1 command byte and replies with position/ID frames.
// Reply starts GUARD_CLKS after oDir rises; iRx is ignored from decode until back in IDLE.
module encoder_responder
    import encoder_responder_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 40,
    parameter int         GUARD_CLKS   = 40,
    parameter logic [7:0] ENC_ID       = 8'h17
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iRx,
    input  logic [23:0] iPos,
    input  logic [7:0]  iStatus,
    output logic        oTx,
    output logic        oDir,
    output logic        oBusy,
    output logic        oFrame_err
);
    localparam int GW = (GUARD_CLKS > 1) ? $clog2(GUARD_CLKS + 1) : 1;

    state_e        state_q;
    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    logic [3:0]    bit_q;
    logic [2:0]    byte_q;
    logic [7:0]    shift_q;
    logic [23:0]   pos_q;
    logic [7:0]    sf_q;
    logic [GW-1:0] gcnt_q;
    logic          tx_q, dir_q, busy_q, ferr_q;

    logic          rx_fall, guard_done, timer_restart, bit_mid, bit_end;
    logic [7:0]    cur_byte;

    assign rx_fall       = rx_prev_q & ~rx_sync_q;
    assign guard_done    = (gcnt_q == GW'(GUARD_CLKS - 1));
    assign timer_restart = ((state_q == ST_IDLE) && rx_fall) ||
                           ((state_q == ST_TX_GUARD) && guard_done);
    assign cur_byte      = reply_byte(shift_q, sf_q, pos_q, ENC_ID, byte_q);

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
        .clk_i     (iClk),
        .rst_ni    (iRst_n),
        .restart_i (timer_restart),
        .mid_o     (bit_mid),
        .end_o     (bit_end)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= ST_IDLE;
            bit_q     <= '0;
            byte_q    <= '0;
            shift_q   <= '0;
            pos_q     <= '0;
            sf_q      <= '0;
            gcnt_q    <= '0;
            tx_q      <= 1'b1;
            dir_q     <= 1'b0;
            busy_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= iRx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            ferr_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_fall) state_q <= ST_RX_START;
                end
                ST_RX_START: begin
                    if (bit_mid) begin
                        if (rx_sync_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_RX_DATA;
                            bit_q   <= '0;
                        end
                    end
                end
                ST_RX_DATA: begin
                    if (bit_mid) begin
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        if (bit_q == 4'd7) state_q <= ST_RX_STOP;
                        else               bit_q   <= bit_q + 4'd1;
                    end
                end
                ST_RX_STOP: begin
                    if (bit_mid) begin
                        if (rx_sync_q) begin
                            state_q <= ST_DECODE;
                            busy_q  <= cmd_valid(shift_q);
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_DECODE: begin
                    pos_q  <= iPos;
                    sf_q   <= iStatus;
                    byte_q <= '0;
                    gcnt_q <= '0;
                    if (cmd_valid(shift_q)) begin
                        dir_q   <= 1'b1;
                        state_q <= ST_TX_GUARD;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_TX_GUARD: begin
                    if (guard_done) begin
                        state_q <= ST_TX_BYTE;
                        tx_q    <= 1'b0;
                        bit_q   <= '0;
                    end else begin
                        gcnt_q  <= gcnt_q + 1'b1;
                    end
                end
                ST_TX_BYTE: begin
                    // bit_q: 0 = start, 1..8 = data LSB first, 9 = stop
                    if (bit_end) begin
                        if (bit_q == 4'd9) begin
                            if (byte_q == reply_last(shift_q)) begin
                                state_q <= ST_TX_HOLD;
                            end else begin
                                byte_q <= byte_q + 3'd1;
                                bit_q  <= '0;
                                tx_q   <= 1'b0;
                            end
                        end else begin
                            bit_q <= bit_q + 4'd1;
                            tx_q  <= (bit_q == 4'd8) ? 1'b1 : cur_byte[bit_q[2:0]];
                        end
                    end
                end
                ST_TX_HOLD: begin
                    if (bit_end) begin
                        dir_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign oTx        = tx_q;
    assign oDir       = dir_q;
    assign oBusy      = busy_q;
    assign oFrame_err = ferr_q;

endmodule

// File: tb/tb_encoder_responder.sv
// Bench for encoder_responder: drives UART command bytes, decodes oTx as a UART receiver
// and compares reply bytes and timing against a protocol-level model.
module tb_encoder_responder;
    localparam int         CPB   = 40;
    localparam int         GUARD = 40;
    localparam logic [7:0] ID    = 8'h17;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_drv = 1'b1;
    logic        echo_en = 1'b0;
    logic [23:0] pos = '0;
    logic [7:0]  sf = '0;
    logic        rx, tx, dir, busy, ferr;

    assign rx = echo_en ? tx : rx_drv;

    always #5 clk = ~clk;

    encoder_responder #(.CLKS_PER_BIT(CPB), .GUARD_CLKS(GUARD), .ENC_ID(ID)) dut (
        .iClk       (clk),
        .iRst_n     (rst_n),
        .iRx        (rx),
        .iPos       (pos),
        .iStatus    (sf),
        .oTx        (tx),
        .oDir       (dir),
        .oBusy      (busy),
        .oFrame_err (ferr)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Edge monitor for oDir / oBusy / oFrame_err
    int   dir_rises = 0, dir_falls = 0, fe_cnt = 0;
    int   dir_rise_cyc = 0, dir_fall_cyc = 0, busy_rise_cyc = 0, busy_fall_cyc = 0;
    logic dir_p = 1'b0, busy_p = 1'b0;
    always @(negedge clk) begin
        if (dir && !dir_p)   begin dir_rises++; dir_rise_cyc = cyc; end
        if (!dir && dir_p)   begin dir_falls++; dir_fall_cyc = cyc; end
        if (busy && !busy_p) busy_rise_cyc = cyc;
        if (!busy && busy_p) busy_fall_cyc = cyc;
        if (ferr) fe_cnt++;
        dir_p  = dir;
        busy_p = busy;
    end

    // UART receiver on oTx; frames cut short by reset are dropped
    logic [7:0] got[$];
    int         starts[$];
    int         stop_bad = 0;
    logic       tx_p = 1'b1;
    initial begin : dec
        logic [7:0] d;
        bit ab;
        d = '0;
        forever begin
            @(negedge clk);
            if (rst_n && tx_p && !tx) begin
                starts.push_back(cyc);
                ab = 1'b0;
                repeat (CPB / 2) begin @(negedge clk); if (!rst_n) ab = 1'b1; end
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) begin @(negedge clk); if (!rst_n) ab = 1'b1; end
                    d[i] = tx;
                end
                repeat (CPB) begin @(negedge clk); if (!rst_n) ab = 1'b1; end
                if (!ab) begin
                    got.push_back(d);
                    if (!tx) stop_bad++;
                end
            end
            tx_p = tx;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (CPB) @(negedge clk);
        rx_drv = 1'b1;
    endtask

    // Protocol-level reply: field list per command, then XOR checksum appended
    task automatic model(input logic [7:0] cmd, input logic [23:0] p, input logic [7:0] s,
                         output int n, output logic [47:0] bytes);
        logic [7:0] q[$];
        logic [7:0] crc;
        crc = '0;
        q   = {};
        if (cmd == 8'h02)      q = {cmd, s, p[7:0], p[15:8], p[23:16]};
        else if (cmd == 8'h92) q = {cmd, s, ID};
        if (q.size() > 0) begin
            foreach (q[i]) crc ^= q[i];
            q.push_back(crc);
        end
        n     = q.size();
        bytes = '0;
        for (int i = 0; i < n; i++) bytes[i*8 +: 8] = q[i];
    endtask

    task automatic run_txn(input logic [7:0] cmd, input logic [23:0] p, input logic [7:0] s,
                           input logic stop_bit, input int exp_n, input logic [47:0] exp_b,
                           input int exp_fe, input bit chg_pos, input bit echo);
        int b_got, b_st, b_dr, b_df, b_fe, b_sb, t;
        b_got = got.size(); b_st = starts.size(); b_dr = dir_rises;
        b_df = dir_falls; b_fe = fe_cnt; b_sb = stop_bad;
        pos = p; sf = s;
        send_byte(cmd, stop_bit);
        if (exp_n > 0) begin
            echo_en = echo;
            t = 0;
            while (dir_rises == b_dr && t < 1000) begin @(negedge clk); t++; end
            if (chg_pos) begin pos = 24'hABCDEF; sf = 8'hFF; end
            t = 0;
            while (dir_falls == b_df && t < 8000) begin @(negedge clk); t++; end
            chk("dir_fall_seen", 32'(dir_falls - b_df), 32'd1);
            echo_en = 1'b0;
            repeat (5) @(negedge clk);
        end else begin
            repeat (3 * CPB) @(negedge clk);
        end
        chk("dir_rises", 32'(dir_rises - b_dr), (exp_n > 0) ? 32'd1 : 32'd0);
        chk("frame_err_pulses", 32'(fe_cnt - b_fe), 32'(exp_fe));
        chk("byte_count", 32'(got.size() - b_got), 32'(exp_n));
        for (int i = 0; i < exp_n && (b_got + i) < got.size(); i++)
            chk($sformatf("reply_byte%0d", i), 32'(got[b_got + i]), 32'(exp_b[i*8 +: 8]));
        if (exp_n > 0 && (starts.size() - b_st) >= exp_n) begin
            chk("guard_clks", 32'(starts[b_st] - dir_rise_cyc), 32'(GUARD));
            for (int i = 1; i < exp_n; i++)
                chk("byte_spacing", 32'(starts[b_st + i] - starts[b_st + i - 1]), 32'(10 * CPB));
            chk("hold_clks", 32'(dir_fall_cyc - starts[b_st + exp_n - 1]), 32'(11 * CPB));
            chk("busy_lead", 32'(dir_rise_cyc - busy_rise_cyc), 32'd1);
            chk("busy_fall", 32'(busy_fall_cyc), 32'(dir_fall_cyc));
            chk("stop_bits", 32'(stop_bad - b_sb), 32'd0);
        end
        chk("busy_idle", 32'(busy), 32'd0);
        chk("tx_idle", 32'(tx), 32'd1);
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] p;
        logic [7:0]  s;
        logic        stop;
        bit          chg;
        int          n;
        logic [47:0] b;
        int          fe;
    } vec_t;

    vec_t vt[7];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0]  c;
        logic [23:0] rp;
        logic [7:0]  rs;
        int          n, t, b_st, b_dr;
        logic [47:0] eb;

        vt[0] = '{8'h02, 24'h123456, 8'h00, 1'b1, 1'b0, 6, 48'h721234560002, 0};
        vt[1] = '{8'h92, 24'h123456, 8'h00, 1'b1, 1'b0, 4, 48'h000085170092, 0};
        vt[2] = '{8'h02, 24'h123456, 8'h00, 1'b0, 1'b0, 0, 48'h0,            1};
        vt[3] = '{8'h55, 24'h123456, 8'h00, 1'b1, 1'b0, 0, 48'h0,            0};
        vt[4] = '{8'h02, 24'h123456, 8'h00, 1'b1, 1'b0, 6, 48'h721234560002, 0};
        vt[5] = '{8'h02, 24'h123456, 8'h00, 1'b1, 1'b1, 6, 48'h721234560002, 0};
        vt[6] = '{8'h92, 24'h000000, 8'hA5, 1'b1, 1'b0, 4, 48'h00002017A592, 0};

        repeat (3) @(negedge clk);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_dir", 32'(dir), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ferr", 32'(ferr), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        foreach (vt[i])
            run_txn(vt[i].cmd, vt[i].p, vt[i].s, vt[i].stop, vt[i].n, vt[i].b, vt[i].fe, vt[i].chg, 1'b0);

        // Short low glitch: start bit reads 1 at mid-sample and is discarded
        b_dr = dir_rises;
        t    = fe_cnt;
        @(negedge clk); rx_drv = 1'b0;
        repeat (6) @(negedge clk); rx_drv = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("glitch_no_dir", 32'(dir_rises - b_dr), 32'd0);
        chk("glitch_no_ferr", 32'(fe_cnt - t), 32'd0);
        run_txn(vt[0].cmd, vt[0].p, vt[0].s, 1'b1, vt[0].n, vt[0].b, 0, 1'b0, 1'b0);

        // Randomized commands with the reply echoed back onto iRx
        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 3))
                0, 1:    c = 8'h02;
                2:       c = 8'h92;
                default: begin
                    c = 8'($urandom);
                    while (c == 8'h02 || c == 8'h92) c = 8'($urandom);
                end
            endcase
            rp = 24'($urandom);
            rs = 8'($urandom);
            model(c, rp, rs, n, eb);
            run_txn(c, rp, rs, 1'b1, n, eb, 0, 1'b0, 1'b1);
        end

        // Reset asserted during the third reply byte
        b_st = starts.size();
        pos = 24'h123456; sf = 8'h00;
        send_byte(8'h02, 1'b1);
        t = 0;
        while ((starts.size() - b_st) < 3 && t < 6000) begin @(negedge clk); t++; end
        chk("third_byte_started", 32'((starts.size() - b_st) >= 3), 32'd1);
        repeat (3 * CPB) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", 32'(tx), 32'd1);
        chk("rst_mid_dir", 32'(dir), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        b_dr = dir_rises;
        repeat (3 * CPB) @(negedge clk);
        chk("rst_no_resume", 32'(dir_rises - b_dr), 32'd0);
        run_txn(vt[0].cmd, vt[0].p, vt[0].s, 1'b1, vt[0].n, vt[0].b, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/encoder_responder.md
ENCODER_RESPONDER -- requirements
Module: encoder_responder

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 40, clocks per UART bit (2.5 Mbps at 100 MHz).
REQ-002 SHALL have parameter GUARD_CLKS, default 40, clocks between oDir rise and first start bit.
REQ-003 SHALL have parameter ENC_ID, default 8'h17, encoder ID byte returned by the ID command.
REQ-004 iClk  input  1  sole clock; all logic on the rising edge.
REQ-005 iRst_n  input  1  asynchronous active-low reset.
REQ-006 iRx  input  1  RS485 receive line, idle high, asynchronous to iClk.
REQ-007 iPos  input  24  current absolute position to report.
REQ-008 iStatus  input  8  status field (SF) to report.
REQ-009 oTx  output  1  RS485 transmit line, idle high.
REQ-010 oDir  output  1  transceiver driver enable, 1 = transmit.
REQ-011 oBusy  output  1  high from request decode until oDir falls.
REQ-012 oFrame_err  output  1  one-cycle pulse on received stop bit = 0.

Function
REQ-013 iRx SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized value.
REQ-014 Frame format: 8N1, LSB first; bits sampled at CLKS_PER_BIT/2 after the detected falling edge, then every CLKS_PER_BIT.
- Start bit reading 1 at mid-sample: discard, return to IDLE.
REQ-015 FSM states: IDLE, RX_START, RX_DATA, RX_STOP, DECODE, TX_GUARD, TX_BYTE, TX_HOLD; reset state IDLE.
REQ-016 RX_STOP with sampled 1 -> DECODE; with sampled 0 -> pulse oFrame_err, return to IDLE, no response.
REQ-017 DECODE (one cycle) SHALL snapshot iPos and iStatus into internal registers; the snapshot is held unchanged through the reply.
REQ-018 Command 8'h02 -> reply of 6 bytes: CF(8'h02), SF, POS[7:0], POS[15:8], POS[23:16], CRC.
REQ-019 Command 8'h92 -> reply of 4 bytes: CF(8'h92), SF, ENC_ID, CRC.
REQ-020 Any other command byte -> return to IDLE, no oDir assertion, no oFrame_err.
REQ-021 CRC SHALL be the bitwise XOR of all preceding reply bytes.
REQ-022 oDir SHALL rise in the cycle after DECODE; the first start bit begins exactly GUARD_CLKS cycles after oDir rises.
REQ-023 Reply bytes SHALL be sent back to back (start, 8 data, stop), each bit exactly CLKS_PER_BIT cycles, with no idle gap between bytes.
REQ-024 TX_HOLD: after the final stop bit, oDir SHALL stay high for CLKS_PER_BIT cycles, then fall; FSM -> IDLE.
REQ-025 iRx SHALL be ignored from DECODE until return to IDLE, so echo on a half-duplex bus is not decoded.
REQ-026 A falling edge on iRx arriving in the same cycle as the return to IDLE SHALL not be captured; detection starts the next cycle.
REQ-027 oTx SHALL be 1 in every state except during start and data-0 bits of TX_BYTE.
REQ-028 oBusy SHALL be high from DECODE (valid command) through the cycle oDir falls.

Reset
REQ-029 On iRst_n low, regardless of state, SHALL immediately force oTx=1, oDir=0, oBusy=0, oFrame_err=0, FSM=IDLE, clear all counters, the snapshot and the synchronizer (to 1).
REQ-030 A reset asserted mid-reply SHALL abort the reply; after release the block waits for a fresh request.

Structure
REQ-031 Command codes (8'h02, 8'h92) and reply lengths SHALL live in a shared encoder protocol package, also used by the encoder master side.
REQ-032 A single sub-module uart_bit_timer (bit-period counter with mid-bit and end-bit strobes) is natural, instantiated once and shared by RX and TX.

Verification
REQ-033 iPos=24'h123456, iStatus=8'h00, send 8'h02 -> oTx bytes 02,00,56,34,12,72; oDir high 40 cycles before first start bit.
REQ-034 Send 8'h92, iStatus=8'h00 -> bytes 92,00,17,85; oDir falls 40 cycles after the last stop bit.
REQ-035 Send 8'h02 with stop bit 0 -> one oFrame_err pulse, oDir stays 0.
REQ-036 Send 8'h55 -> no oDir, no oFrame_err; following 8'h02 answered normally.
REQ-037 Change iPos to 24'hABCDEF during a reply -> transmitted position bytes still 56,34,12.
REQ-038 Assert iRst_n low during the 3rd reply byte -> oTx=1, oDir=0 within the same cycle; next 8'h02 answered fully.
